// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, control type and skid-buffer occupancy states.
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t OP_ADD  = 3'b000;
  localparam alu_ctrl_t OP_SUB  = 3'b001;
  localparam alu_ctrl_t OP_AND  = 3'b010;
  localparam alu_ctrl_t OP_OR   = 3'b011;
  localparam alu_ctrl_t OP_XOR  = 3'b100;
  localparam alu_ctrl_t OP_SHL2 = 3'b101;
  localparam alu_ctrl_t OP_SHR2 = 3'b110;
  localparam alu_ctrl_t OP_INC  = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid are registered.
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         occ, occ_next;
  logic [W-1:0] skid;
  logic         push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    occ_next = occ;
    unique case (occ)
      EMPTY:   if (push) occ_next = ONE;
      ONE: begin
        if (push && !pop)      occ_next = FULL;
        else if (!push && pop) occ_next = EMPTY;
      end
      FULL:    if (pop) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      unique case (occ)
        EMPTY: if (push) out_data <= in_data;
        ONE: begin
          if (push && pop) out_data <= in_data;
          else if (push)   skid     <= in_data;
        end
        FULL:    if (pop) out_data <= skid;
        default: ;
      endcase
      occ       <= occ_next;
      // Both flags come from the next occupancy so they stay pure flops.
      in_ready  <= (occ_next != FULL);
      out_valid <= (occ_next != EMPTY);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with skid buffer and saturating zero-result counter.
// Optional macro ALU_RES_PARITY_EN adds per-entry even parity on out_parity.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic             in_zero,
  input  alu_ctrl_t        in_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_zero,
  output logic             out_neg,
  output alu_ctrl_t        out_control,
`ifdef ALU_RES_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] zero_count
);

`ifdef ALU_RES_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned W = N + 5 + PW;

  logic [W-1:0] pack_in, pack_out;

`ifdef ALU_RES_PARITY_EN
  assign pack_in = {^in_result, in_result, in_zero, in_result[N-1], in_control};
  assign {out_parity, out_result, out_zero, out_neg, out_control} = pack_out;
`else
  assign pack_in = {in_result, in_zero, in_result[N-1], in_control};
  assign {out_result, out_zero, out_neg, out_control} = pack_out;
`endif

  alu_skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pack_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pack_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero_count <= '0;
    else if (in_valid && in_ready && in_zero && (zero_count != '1))
      zero_count <= zero_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (N=32, CNT_W=2).
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_zero = 1'b0;
  alu_ctrl_t   in_control = OP_ADD;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
  alu_ctrl_t   out_control;
`ifdef ALU_RES_PARITY_EN
  logic        out_parity;
`endif
  logic [1:0]  zero_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.N(32), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_control  (in_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_control (out_control),
`ifdef ALU_RES_PARITY_EN
    .out_parity  (out_parity),
`endif
    .zero_count  (zero_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_zero_count", 64'(zero_count), 64'd0);
    chk("rst_out_fields", {27'd0, out_result, out_zero, out_neg, out_control}, 64'd0);

    // single transfer
    in_valid = 1'b1; in_result = 32'd5; in_zero = 1'b0; in_control = OP_ADD;
    step();
    in_valid = 1'b0;
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_out_result", 64'(out_result), 64'd5);
    chk("first_zero_ctrl", {out_zero, out_neg, out_control}, {2'b00, OP_ADD});
    step();
    chk("first_drained", 64'(out_valid), 64'd0);

    // back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h10; in_control = OP_SUB;
    step();
    chk("bp_ready_after_one", 64'(in_ready), 64'd1);
    in_result = 32'h20; in_control = OP_XOR;
    step();
    in_valid = 1'b0;
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_head", {out_valid, out_result, out_control}, {1'b1, 32'h10, OP_SUB});
    in_valid = 1'b1; in_result = 32'h99;
    step();
    in_valid = 1'b0;
    chk("bp_hold", {in_ready, out_valid, out_result, out_control}, {2'b01, 32'h10, OP_SUB});
    out_ready = 1'b1;
    step();
    chk("bp_second", {in_ready, out_valid, out_result, out_control}, {2'b11, 32'h20, OP_XOR});
    step();
    chk("bp_drained", {in_ready, out_valid}, 64'b10);

    // streaming, one per cycle
    in_control = OP_AND;
    for (int unsigned i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_result = i;
      step();
      chk($sformatf("stream_%0d", i), {in_ready, out_valid, out_result}, {2'b11, i});
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_no_zero", 64'(zero_count), 64'd0);

    // zero counter saturation with CNT_W=2
    in_zero = 1'b1; in_control = OP_OR;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_result = '0;
      step();
      chk($sformatf("zcnt_%0d", i), 64'(zero_count), (i < 3) ? 64'(i + 1) : 64'd3);
      chk($sformatf("zflag_%0d", i), {out_valid, out_zero}, 64'b11);
    end
    in_zero = 1'b0; in_result = 32'h8000_0000; in_control = OP_SHL2;
    step();
    in_valid = 1'b0;
    chk("neg_flag", {out_neg, out_zero, out_control}, {2'b10, OP_SHL2});
    chk("zcnt_hold", 64'(zero_count), 64'd3);
    step();

`ifdef ALU_RES_PARITY_EN
    in_valid = 1'b1; in_result = 32'h7;
    step();
    chk("parity_7", 64'(out_parity), 64'd1);
    in_result = 32'h3;
    step();
    in_valid = 1'b0;
    chk("parity_3", 64'(out_parity), 64'd0);
    step();
`endif

    // asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_zero = 1'b1; in_result = 32'hA5;
    step();
    in_result = 32'h5A;
    step();
    in_valid = 1'b0; in_zero = 1'b0;
    chk("pre_rst_full", {in_ready, out_valid}, 64'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_flags", {in_ready, out_valid}, 64'b10);
    chk("async_rst_count", 64'(zero_count), 64'd0);
    chk("async_rst_result", 64'(out_result), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_empty", {in_ready, out_valid}, 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
